// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner: strobes active-low columns one at a time, samples the
// active-low rows through a 2-flop synchronizer and debounces every key into a
// bitmap. Defining KEYSCAN_EVENTS_EN adds a press/release event port with a
// valid/ready handshake; without it the event outputs are tied low.

module key_matrix_scanner #(
    parameter int COLS     = 4,
    parameter int ROWS     = 8,
    parameter int SCAN_DIV = 12000,
    parameter int DEBOUNCE = 4
) (
    input  logic                          clk12MHz,
    input  logic                          reset,
    input  logic [ROWS-1:0]               row_in,
    output logic [COLS-1:0]               col_out,
    output logic [ROWS*COLS-1:0]          keys,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [$clog2(ROWS*COLS)-1:0]  ev_key,
    output logic                          ev_pressed
);

    localparam int NKEYS = ROWS * COLS;
    localparam int KW    = $clog2(NKEYS);
    localparam int CW    = $clog2(DEBOUNCE + 1);
    localparam int SW    = $clog2(SCAN_DIV);
    localparam int CIW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RIW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        SETTLE,
        SAMPLE,
        UPDATE,
        NEXT
    } state_t;

    state_t          state_q;
    logic [SW-1:0]   settle_q;
    logic [CIW-1:0]  col_q;
    logic [RIW-1:0]  row_q;
    logic [ROWS-1:0] sync1_q;
    logic [ROWS-1:0] sync2_q;
    logic [ROWS-1:0] samp_q;
    logic [COLS-1:0] col_out_q;
    logic [NKEYS-1:0] keys_q;
    logic [CW-1:0]   cnt_q [NKEYS];

    logic [KW-1:0]   k_idx;
    logic [CIW-1:0]  col_d;
    logic            differ;
    logic            flip_due;
    logic            stall;

    // Key under the UPDATE pointer and whether its debounce completes this cycle
    always_comb begin
        k_idx    = KW'(col_q) * KW'(ROWS) + KW'(row_q);
        differ   = samp_q[row_q] != keys_q[k_idx];
        flip_due = (state_q == UPDATE) && differ && (cnt_q[k_idx] == CW'(DEBOUNCE - 1));
        col_d    = (col_q == CIW'(COLS - 1)) ? '0 : col_q + 1'b1;
    end

    // Two-flop synchronizer for the asynchronous row pins
    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= row_in;
            sync2_q <= sync1_q;
        end
    end

    // Scan FSM: settle the strobe, sample rows, debounce one row per cycle, advance column
    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            state_q   <= SETTLE;
            settle_q  <= '0;
            col_q     <= '0;
            row_q     <= '0;
            samp_q    <= '0;
            col_out_q <= ~COLS'(1);
            keys_q    <= '0;
            for (int unsigned i = 0; i < NKEYS; i++) cnt_q[i] <= '0;
        end else begin
            case (state_q)
                SETTLE: begin
                    if (settle_q == SW'(SCAN_DIV - 1)) begin
                        settle_q <= '0;
                        state_q  <= SAMPLE;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                SAMPLE: begin
                    samp_q  <= ~sync2_q;
                    row_q   <= '0;
                    state_q <= UPDATE;
                end
                UPDATE: begin
                    if (!stall) begin
                        if (!differ) begin
                            cnt_q[k_idx] <= '0;
                        end else if (flip_due) begin
                            keys_q[k_idx] <= ~keys_q[k_idx];
                            cnt_q[k_idx]  <= '0;
                        end else begin
                            cnt_q[k_idx] <= cnt_q[k_idx] + 1'b1;
                        end
                        if (row_q == RIW'(ROWS - 1)) state_q <= NEXT;
                        else                         row_q   <= row_q + 1'b1;
                    end
                end
                NEXT: begin
                    col_q     <= col_d;
                    col_out_q <= ~(COLS'(1) << col_d);
                    settle_q  <= '0;
                    state_q   <= SETTLE;
                end
                default: state_q <= SETTLE;
            endcase
        end
    end

    assign col_out = col_out_q;
    assign keys    = keys_q;

`ifdef KEYSCAN_EVENTS_EN
    logic          ev_valid_q;
    logic          ev_pressed_q;
    logic [KW-1:0] ev_key_q;

    // A flip cannot be committed while the previous event is still unaccepted
    assign stall = flip_due && ev_valid_q && !ev_ready;

    // Event register: drop on transfer, reload on a committed flip (load wins)
    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            ev_valid_q   <= 1'b0;
            ev_key_q     <= '0;
            ev_pressed_q <= 1'b0;
        end else begin
            if (ev_valid_q && ev_ready) ev_valid_q <= 1'b0;
            if (flip_due && !stall) begin
                ev_valid_q   <= 1'b1;
                ev_key_q     <= k_idx;
                ev_pressed_q <= ~keys_q[k_idx];
            end
        end
    end

    assign ev_valid   = ev_valid_q;
    assign ev_key     = ev_key_q;
    assign ev_pressed = ev_pressed_q;
`else
    logic unused_ev_ready;

    assign stall           = 1'b0;
    assign ev_valid        = 1'b0;
    assign ev_key          = '0;
    assign ev_pressed      = 1'b0;
    assign unused_ev_ready = ev_ready;
`endif

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Testbench for key_matrix_scanner: a physical key matrix model drives the rows
// from the strobed columns, and a per-visit debounce model predicts the key
// bitmap and the ordered press/release event stream.

module tb_key_matrix_scanner;

    localparam int COLS = 4;
    localparam int ROWS = 8;
    localparam int SDIV = 8;
    localparam int DEB  = 2;
    localparam int NK   = COLS * ROWS;

    logic            clk12MHz = 1'b0;
    logic            reset    = 1'b1;
    logic            ev_ready = 1'b1;
    logic [ROWS-1:0] row_in;
    logic [COLS-1:0] col_out;
    logic [NK-1:0]   keys;
    logic            ev_valid;
    logic [4:0]      ev_key;
    logic            ev_pressed;

    key_matrix_scanner #(
        .COLS(COLS), .ROWS(ROWS), .SCAN_DIV(SDIV), .DEBOUNCE(DEB)
    ) dut (
        .clk12MHz(clk12MHz), .reset(reset), .row_in(row_in), .col_out(col_out),
        .keys(keys), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_key(ev_key),
        .ev_pressed(ev_pressed)
    );

    always #5 clk12MHz = ~clk12MHz;

    // Physical matrix: a closed key pulls its row low while its column is strobed
    logic [NK-1:0] phys = '0;
    always_comb begin
        row_in = '1;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                if (!col_out[c] && phys[c*ROWS+r]) row_in[r] = 1'b0;
    end

    typedef struct {
        int   key;
        logic pressed;
    } ev_t;

    int vectors    = 0;
    int miscompares = 0;
    bit rand_ready = 1'b0;

    logic [NK-1:0]   kexp;
    int              cnt [NK];
    logic [COLS-1:0] last_col;
    int              nedge;
    logic [NK-1:0]   snap;
    ev_t             exp_q[$];
    ev_t             obs_q[$];

    // Reference model evaluated once per completed column visit
    always @(negedge clk12MHz) begin
        if (reset) begin
            kexp     = '0;
            for (int i = 0; i < NK; i++) cnt[i] = 0;
            last_col = 4'b1110;
            nedge    = 0;
            snap     = '0;
            exp_q.delete();
            obs_q.delete();
        end else begin
`ifdef KEYSCAN_EVENTS_EN
            if (ev_valid && ev_ready) obs_q.push_back('{int'(ev_key), ev_pressed});
`else
            vectors++;
            if (ev_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL ev_valid_tied: got %b want 0", ev_valid);
            end
`endif
            if (col_out !== last_col) begin
                int pc;
                pc = 0;
                for (int c = 0; c < COLS; c++) if (!last_col[c]) pc = c;
                for (int r = 0; r < ROWS; r++) begin
                    int k;
                    k = pc * ROWS + r;
                    if (snap[k] == kexp[k]) cnt[k] = 0;
                    else begin
                        cnt[k]++;
                        if (cnt[k] == DEB) begin
                            kexp[k] = ~kexp[k];
                            cnt[k]  = 0;
                            exp_q.push_back('{k, kexp[k]});
                        end
                    end
                end
                vectors++;
                if (keys !== kexp) begin
                    miscompares++;
                    $display("FAIL visit_keys col %0d: got %h want %h", pc, keys, kexp);
                end
                last_col = col_out;
                nedge    = 0;
            end else begin
                nedge++;
                if (nedge == 3) snap = phys;
            end
        end
    end

    task automatic step();
        @(posedge clk12MHz);
        #1;
    endtask

    // Wait until column c (any column if c < 0) starts its settle phase
    task automatic wait_col(input int c);
        logic [COLS-1:0] prev, one, tgt;
        int n;
        one  = 1;
        tgt  = ~(one << ((c < 0) ? 0 : c));
        prev = col_out;
        n    = 0;
        while (1) begin
            step();
            n++;
            if (rand_ready) ev_ready = 1'($urandom_range(0, 1));
            if (col_out !== prev && (c < 0 || col_out === tgt)) break;
            prev = col_out;
            if (n > 600) begin
                vectors++;
                miscompares++;
                $display("FAIL wait_col timeout: column %0d not reached, col_out=%b", c, col_out);
                break;
            end
        end
    endtask

    task automatic settle(input int frames);
        repeat (frames * COLS) wait_col(-1);
    endtask

    task automatic check_events(input string name);
`ifdef KEYSCAN_EVENTS_EN
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL %s event_count: got %0d want %0d", name, obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o, e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            vectors++;
            if (o.key != e.key || o.pressed !== e.pressed) begin
                miscompares++;
                $display("FAIL %s event: got key %0d pressed %b want key %0d pressed %b",
                         name, o.key, o.pressed, e.key, e.pressed);
            end
        end
`endif
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        logic [COLS-1:0] one;
        one = 1;
        repeat (3) begin
            step();
            vectors++;
            if (col_out !== 4'b1110 || keys !== '0 || ev_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_values: got col %b keys %h v %b want 1110 0 0",
                         col_out, keys, ev_valid);
            end
        end
        reset = 1'b0;
        for (int i = 1; i <= 72; i++) begin
            logic [COLS-1:0] want;
            step();
            want = ~(one << ((i / (SDIV + ROWS + 2)) % COLS));
            vectors++;
            if (col_out !== want) begin
                miscompares++;
                $display("FAIL col_timing cycle %0d: got %b want %b", i, col_out, want);
            end
        end
    endtask

    task automatic test_single_press();
        wait_col(1);
        phys[11] = 1'b1;
        wait_col(1);
        repeat (12) step();
        vectors++;
        if (keys[11] !== 1'b0) begin
            miscompares++;
            $display("FAIL press_early: got keys[11]=%b want 0", keys[11]);
        end
        step();
        vectors++;
        if (keys[11] !== 1'b1) begin
            miscompares++;
            $display("FAIL press_flip: got keys[11]=%b want 1", keys[11]);
        end
`ifdef KEYSCAN_EVENTS_EN
        vectors++;
        if (ev_valid !== 1'b1 || ev_key !== 5'd11 || ev_pressed !== 1'b1) begin
            miscompares++;
            $display("FAIL press_event: got v%b key %0d p%b want v1 key 11 p1",
                     ev_valid, ev_key, ev_pressed);
        end
`endif
        wait_col(1);
        phys[11] = 1'b0;
        wait_col(1);
        wait_col(2);
        vectors++;
        if (keys[11] !== 1'b0) begin
            miscompares++;
            $display("FAIL release: got keys[11]=%b want 0", keys[11]);
        end
        settle(2);
        check_events("single");
    endtask

    task automatic test_bounce();
        check_events("pre_bounce");
        wait_col(0); phys[0] = 1'b1;
        wait_col(0); phys[0] = 1'b0;
        wait_col(0); phys[0] = 1'b1;
        wait_col(0);
        vectors++;
        if (keys[0] !== 1'b0 || obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL bounce_early: got keys[0]=%b events %0d want 0 0", keys[0], obs_q.size());
        end
        wait_col(1);
        vectors++;
        if (keys[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL bounce_flip: got keys[0]=%b want 1", keys[0]);
        end
`ifdef KEYSCAN_EVENTS_EN
        vectors++;
        if (obs_q.size() != 1 || obs_q[0].key != 0 || obs_q[0].pressed !== 1'b1) begin
            miscompares++;
            $display("FAIL bounce_event: got %0d events want one press of key 0", obs_q.size());
        end
`endif
        phys[0] = 1'b0;
        settle(3);
        check_events("bounce");
    endtask

    task automatic test_backpressure();
        check_events("pre_bp");
        wait_col(0);
        phys[2] = 1'b1;
        phys[5] = 1'b1;
        wait_col(0);
`ifdef KEYSCAN_EVENTS_EN
        ev_ready = 1'b0;
        repeat (19) step();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (ev_valid !== 1'b1 || ev_key !== 5'd2 || ev_pressed !== 1'b1 ||
                keys[2] !== 1'b1 || keys[5] !== 1'b0 || col_out !== 4'b1110) begin
                miscompares++;
                $display("FAIL bp_hold %0d: got v%b key %0d p%b k2 %b k5 %b col %b want v1 key 2 p1 k2 1 k5 0 col 1110",
                         i, ev_valid, ev_key, ev_pressed, keys[2], keys[5], col_out);
            end
            step();
        end
        ev_ready = 1'b1;
        step();
        vectors++;
        if (ev_valid !== 1'b1 || ev_key !== 5'd5 || ev_pressed !== 1'b1 || keys[5] !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: got v%b key %0d p%b k5 %b want v1 key 5 p1 k5 1",
                     ev_valid, ev_key, ev_pressed, keys[5]);
        end
        step();
        vectors++;
        if (ev_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drop: got ev_valid=%b want 0", ev_valid);
        end
`else
        repeat (25) step();
`endif
        phys[2] = 1'b0;
        phys[5] = 1'b0;
        settle(3);
        check_events("bp");
    endtask

    task automatic test_all_keys();
        check_events("pre_all");
        wait_col(0);
        phys = '1;
        settle(3);
        vectors++;
        if (keys !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL all_keys: got %h want ffffffff", keys);
        end
`ifdef KEYSCAN_EVENTS_EN
        vectors++;
        if (obs_q.size() != NK) begin
            miscompares++;
            $display("FAIL all_count: got %0d want %0d", obs_q.size(), NK);
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i].key != i || obs_q[i].pressed !== 1'b1) begin
                miscompares++;
                $display("FAIL all_order %0d: got key %0d p%b want key %0d p1",
                         i, obs_q[i].key, obs_q[i].pressed, i);
            end
        end
`endif
        check_events("all");
    endtask

    task automatic test_random();
        rand_ready = 1'b1;
        for (int v = 0; v < 60; v++) begin
            wait_col(-1);
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 3) == 0) phys[k] = ~phys[k];
        end
        rand_ready = 1'b0;
        ev_ready   = 1'b1;
        settle(3);
        check_events("random");
    endtask

    task automatic test_reset_mid_stall();
        wait_col(0);
        ev_ready = 1'b0;
        phys     = ~phys;
        repeat (200) step();
`ifdef KEYSCAN_EVENTS_EN
        vectors++;
        if (ev_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_pending: got ev_valid=%b want 1", ev_valid);
        end
`endif
        reset = 1'b1;
        phys  = '0;
        step();
        vectors++;
        if (col_out !== 4'b1110 || keys !== '0 || ev_valid !== 1'b0 ||
            ev_key !== 5'd0 || ev_pressed !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: got col %b keys %h v%b key %0d p%b want 1110 0 0 0 0",
                     col_out, keys, ev_valid, ev_key, ev_pressed);
        end
        reset    = 1'b0;
        ev_ready = 1'b1;
        settle(2);
        vectors++;
        if (keys !== '0) begin
            miscompares++;
            $display("FAIL after_reset: got keys %h want 0", keys);
        end
        check_events("after_reset");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_backpressure();
        test_all_keys();
        test_random();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/key_matrix_scanner.md
# key_matrix_scanner

- Input-side counterpart of the LED matrix display driver: strobes matrix columns one at a time, samples active-low row lines, debounces every key and keeps a debounced key bitmap.
- Each debounced change is also issued as a press/release event over a valid/ready handshake.
- Sits between the board's key/button matrix pins and the application logic, in the same clock domain as the display.

## Interface

Parameters:
- COLS, 4, number of column strobes.
- ROWS, 8, number of row inputs.
- SCAN_DIV, 12000, settle cycles per column; legal range 3..2^20.
- DEBOUNCE, 4, consecutive differing samples needed to flip a key; legal range 1..15.

Ports:
- clk12MHz  input  1  the single clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- row_in  input  ROWS  raw row pins, active-low (0 = key closed on the driven column).
- col_out  output  COLS  column strobes, active-low one-hot.
- keys  output  ROWS*COLS  debounced state; bit col*ROWS+row, 1 = pressed.
- ev_valid  output  1  event available.
- ev_ready  input  1  consumer accepts the event.
- ev_key  output  clog2(ROWS*COLS)  key index of the event.
- ev_pressed  output  1  1 = press, 0 = release.

## Operation

- row_in passes through a 2-flop synchronizer. SAMPLE uses the synchronizer output and inverts it, so sample bit 1 = pressed.
- Each key has a debounce counter of clog2(DEBOUNCE+1) bits.
- FSM states and transitions:
  - SETTLE: col_out drives column c low and all other columns high. Counts SCAN_DIV cycles, then goes to SAMPLE.
  - SAMPLE: captures the synchronized, inverted rows into a ROWS-bit register. Sets row index r=0. Goes to UPDATE.
  - UPDATE: processes one row per cycle. Let k = c*ROWS+r.
    - sample == keys[k]: counter clears.
    - Otherwise the counter increments. When it reaches DEBOUNCE, keys[k] flips, the counter clears and an event loads.
    - After r = ROWS-1, goes to NEXT.
  - NEXT: c = (c+1) mod COLS, wrapping to column 0 after COLS-1. Goes to SETTLE.
- Event load: ev_key=k, ev_pressed=new keys[k], ev_valid=1. All three are registered and visible the cycle after the UPDATE cycle, together with the new keys bit.
- Stall: if a flip is due while ev_valid=1 and ev_ready=0, UPDATE holds r. keys, the counter and the event registers stay unchanged until ev_ready is seen.
- Transfer: a cycle with ev_valid&&ev_ready.
  - If no new event loads in that cycle, ev_valid drops the next cycle.
  - A new event may load in the same cycle as a transfer, giving back-to-back events with no gap.
- ev_key and ev_pressed are stable while ev_valid=1 and ev_ready=0.
- Simultaneous flips on the same column are issued in ascending row order, one per cycle at most.

## Timing

- Reset values:
  - col_out = all ones except bit 0 low.
  - keys = 0, ev_valid = 0, ev_key = 0, ev_pressed = 0.
  - All debounce counters = 0; FSM in SETTLE with c=0 and the settle counter at 0.
- Reset asserted mid-scan or mid-stall applies the same values on the next edge. A pending event is discarded.
- Column period without stalls: SCAN_DIV+ROWS+2 cycles. Full matrix frame: COLS times that.
- Input-to-sample latency: 2 synchronizer cycles. SCAN_DIV ≥ 3 guarantees the sample reflects the strobe.
- Press to event, stable input, no stalls:
  - Requires DEBOUNCE visits to that column.
  - The event appears 1 cycle after the key's UPDATE cycle of the DEBOUNCE-th visit.
- A bounce during counting (sample equals keys) clears the counter; counting restarts from 0.

## Configuration

- KEYSCAN_EVENTS_EN defined: event registers and handshake are compiled in, and stalls apply as above.
- KEYSCAN_EVENTS_EN undefined:
  - Event registers and handshake are removed.
  - ev_valid, ev_key and ev_pressed are tied to 0; ev_ready is ignored.
  - UPDATE never stalls; keys still updates identically.

## Test plan

All scenarios use SCAN_DIV=8, DEBOUNCE=2, COLS=4, ROWS=8; ev_ready=1 unless stated.

- Reset:
  - Stimulus: reset high 3 cycles, then low.
  - Required: col_out=4'b1110, keys=0, ev_valid=0 during reset.
  - Required: col_out=4'b1101 exactly 18 cycles after reset release, 4'b1110 again after 72 cycles.
- Single press:
  - Stimulus: row_in[3]=0 only while col_out[1]=0.
  - Required: on the 2nd visit to column 1, keys[11]=1 and one event ev_key=11, ev_pressed=1.
  - Required: row_in[3] back to 1 later gives ev_key=11, ev_pressed=0 after 2 visits.
- Bounce:
  - Stimulus: key 0 pressed for 1 visit, released for 1 visit, pressed for 2 visits.
  - Required: exactly one press event, on the 4th visit; no event earlier.
- Back-pressure:
  - Stimulus: ev_ready=0 while rows 2 and 5 of column 0 flip in the same scan.
  - Required: ev_key=2 held stable and UPDATE stalled at r=5; keys[5] still 0.
  - Required: after ev_ready=1 for 1 cycle, ev_key=5 is valid the next cycle, then ev_valid drops.
- Wrap and all keys:
  - Stimulus: all 32 keys pressed.
  - Required: 32 press events in ascending ev_key order 0..31; keys=32'hFFFFFFFF.
- Macro off:
  - Stimulus: rerun the single-press scenario without KEYSCAN_EVENTS_EN.
  - Required: keys[11] identical timing; ev_valid constantly 0.
